// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: credit-based round-robin scheduler that merges the user
// output streams of a leaf page onto the single leaf-to-BFT packet output.
// Optional feature macro: LEAF_ARB_CREDIT_EN (per-port credit counters).
module leaf_out_arbiter #(
   parameter int unsigned PACKET_BITS           = 49,
   parameter int unsigned PAYLOAD_BITS          = 32,
   parameter int unsigned NUM_LEAF_BITS         = 5,
   parameter int unsigned NUM_PORT_BITS         = 4,
   parameter int unsigned NUM_ADDR_BITS         = 7,
   parameter int unsigned NUM_OUT_PORTS         = 3,
   parameter int unsigned NUM_BRAM_ADDR_BITS    = 7,
   parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  ap_start,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
   input  logic                                  cfg_wr_en,
   input  logic [2:0]                            cfg_port,
   input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
   input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
   input  logic                                  credit_upd_vld,
   input  logic [2:0]                            credit_upd_port,
   output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
   output logic                                  dout_vld,
   input  logic                                  dout_rdy
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                   state_q, state_d;
   logic [NUM_OUT_PORTS-1:0] cfg_valid_q;
   logic [NUM_LEAF_BITS-1:0] dest_leaf_q [NUM_OUT_PORTS];
   logic [NUM_PORT_BITS-1:0] dest_port_q [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] seq_addr_q  [NUM_OUT_PORTS];
   logic [2:0]               last_grant_q;
   logic [2:0]               grant_idx;
   logic                     found;
   logic [NUM_OUT_PORTS-1:0] credit_ok;
   logic [NUM_OUT_PORTS-1:0] eligible;
   logic [NUM_OUT_PORTS-1:0] grant;
   logic                     grant_en;
   logic                     can_load;
   logic                     xfer;
   logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
   logic                     pkt_vld_q;

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next state: ap_start level gates arbitration
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (ap_start)  state_d = StRun;
         StRun:   if (!ap_start) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A new word may enter the output register only if it is empty or draining now
   assign grant_en = (state_q == StRun);
   assign can_load = !pkt_vld_q || dout_rdy;
   assign eligible = vld_user2interface & cfg_valid_q & credit_ok;

   // Round-robin pick: first eligible port at distance 1..N after the last grant
   always_comb begin
      grant     = '0;
      grant_idx = last_grant_q;
      found     = 1'b0;
      if (grant_en && can_load) begin
         for (int k = 1; k <= int'(NUM_OUT_PORTS); k++) begin
            for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
               if (!found && eligible[i] &&
                   ((int'(last_grant_q) + k == i) ||
                    (int'(last_grant_q) + k == i + int'(NUM_OUT_PORTS)))) begin
                  found     = 1'b1;
                  grant[i]  = 1'b1;
                  grant_idx = 3'(i);
               end
            end
         end
      end
   end

   assign ack_interface2user = grant;
   assign xfer               = |(grant & vld_user2interface);

   // Packet assembly for the granted port
   always_comb begin
      pkt_d = pkt_q;
      for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
         if (grant[i]) begin
            pkt_d = {1'b1, dest_leaf_q[i], dest_port_q[i], seq_addr_q[i],
                     din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
         end
      end
   end

   // Output register: holds the packet stable until dout_rdy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_q     <= '0;
         pkt_vld_q <= 1'b0;
      end else if (xfer) begin
         pkt_q     <= pkt_d;
         pkt_vld_q <= 1'b1;
      end else if (dout_rdy) begin
         pkt_vld_q <= 1'b0;
      end
   end

   assign dout_leaf_interface2bft = pkt_q;
   assign dout_vld                = pkt_vld_q;

   // Per-port destination table, sequence counters and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_valid_q  <= '0;
         last_grant_q <= 3'(NUM_OUT_PORTS - 1);
         for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
            dest_leaf_q[i] <= '0;
            dest_port_q[i] <= '0;
            seq_addr_q[i]  <= '0;
         end
      end else begin
         if (xfer) last_grant_q <= grant_idx;
         for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
            // Out-of-range cfg_port never matches any i, so it is dropped
            if (cfg_wr_en && (cfg_port == 3'(i))) begin
               cfg_valid_q[i] <= 1'b1;
               dest_leaf_q[i] <= cfg_dest_leaf;
               dest_port_q[i] <= cfg_dest_port;
            end
            if (grant[i]) seq_addr_q[i] <= seq_addr_q[i] + 1'b1;
         end
      end
   end

`ifdef LEAF_ARB_CREDIT_EN
   localparam int unsigned CreditW = NUM_BRAM_ADDR_BITS + 1;
   localparam logic [CreditW:0] CreditMax = (CreditW+1)'(1 << NUM_BRAM_ADDR_BITS);
   localparam logic [CreditW:0] UpdAmt    = (CreditW+1)'(FREESPACE_UPDATE_SIZE);

   logic [CreditW-1:0] credit_q   [NUM_OUT_PORTS];
   logic [CreditW:0]   credit_sum [NUM_OUT_PORTS];

   // Credit next value: one extra bit so decrement+update can exceed max before saturating
   always_comb begin
      for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
         credit_sum[i] = {1'b0, credit_q[i]} - {{CreditW{1'b0}}, grant[i]} +
                         ((credit_upd_vld && (credit_upd_port == 3'(i))) ? UpdAmt : '0);
         if (credit_sum[i] > CreditMax) credit_sum[i] = CreditMax;
         credit_ok[i] = (credit_q[i] != '0);
      end
   end

   // Credit counters mirror free space in the destination buffers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_OUT_PORTS); i++) credit_q[i] <= CreditMax[CreditW-1:0];
      end else begin
         for (int i = 0; i < int'(NUM_OUT_PORTS); i++) credit_q[i] <= credit_sum[i][CreditW-1:0];
      end
   end
`else
   logic unused_credit;

   assign credit_ok     = '1;
   assign unused_credit = ^{credit_upd_vld, credit_upd_port};
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter with a packet scoreboard.
// Honours LEAF_ARB_CREDIT_EN the same way the design does.
module tb_leaf_out_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ap_start;
   logic [95:0] din;
   logic [2:0]  vld;
   logic [2:0]  ack;
   logic        cfg_wr_en;
   logic [2:0]  cfg_port;
   logic [4:0]  cfg_dest_leaf;
   logic [3:0]  cfg_dest_port;
   logic        credit_upd_vld;
   logic [2:0]  credit_upd_port;
   logic [48:0] dout;
   logic        dout_vld;
   logic        dout_rdy;

   // Bench model state
   logic [4:0]  leaf_m [3];
   logic [3:0]  port_m [3];
   logic [6:0]  seq_m  [3];
   logic [31:0] base   [3];
   logic [31:0] cnt    [3];
   int          cred   [3];
   logic        exp_vld;
   logic [48:0] sb [$];
   int          n_vec;
   int          n_mis;

   leaf_out_arbiter dut (
      .clk                     (clk),
      .reset                   (reset),
      .ap_start                (ap_start),
      .din_leaf_user2interface (din),
      .vld_user2interface      (vld),
      .ack_interface2user      (ack),
      .cfg_wr_en               (cfg_wr_en),
      .cfg_port                (cfg_port),
      .cfg_dest_leaf           (cfg_dest_leaf),
      .cfg_dest_port           (cfg_dest_port),
      .credit_upd_vld          (credit_upd_vld),
      .credit_upd_port         (credit_upd_port),
      .dout_leaf_interface2bft (dout),
      .dout_vld                (dout_vld),
      .dout_rdy                (dout_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [48:0] got, input logic [48:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit has_credit(input int i);
`ifdef LEAF_ARB_CREDIT_EN
      return cred[i] != 0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic drive_din();
      din = {base[2] + cnt[2], base[1] + cnt[1], base[0] + cnt[0]};
   endtask

   task automatic model_reset();
      sb.delete();
      exp_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         seq_m[i] = '0;
         cred[i]  = 128;
      end
   endtask

   task automatic cfg_write(input logic [2:0] p, input logic [4:0] lf, input logic [3:0] dp);
      cfg_wr_en     = 1'b1;
      cfg_port      = p;
      cfg_dest_leaf = lf;
      cfg_dest_port = dp;
      if (p < 3) begin
         leaf_m[p] = lf;
         port_m[p] = dp;
      end
   endtask

   // One cycle: check outputs before the edge, update the model, advance
   task automatic step(input logic [2:0] exp_ack);
      logic [48:0] pkt;
      logic        any_xfer;
      @(negedge clk);
      chk("ack", 49'(ack), 49'(exp_ack));
      chk("dout_vld", 49'(dout_vld), 49'(exp_vld));
      if (exp_vld && (sb.size() > 0)) begin
         chk("packet", dout, sb[0]);
         if (dout_rdy) void'(sb.pop_front());
      end
      any_xfer = |(exp_ack & vld);
      for (int i = 0; i < 3; i++) begin
         if (exp_ack[i] && vld[i]) begin
            pkt = {1'b1, leaf_m[i], port_m[i], seq_m[i], base[i] + cnt[i]};
            sb.push_back(pkt);
            seq_m[i]++;
            cnt[i]++;
         end
         cred[i] = cred[i] - int'(exp_ack[i] & vld[i]) +
                   ((credit_upd_vld && (credit_upd_port == 3'(i))) ? 64 : 0);
         if (cred[i] > 128) cred[i] = 128;
      end
      exp_vld = any_xfer ? 1'b1 : (dout_rdy ? 1'b0 : exp_vld);
      @(posedge clk);
      #1;
      drive_din();
   endtask

   initial begin
      n_vec = 0;
      n_mis = 0;
      reset = 1'b1;
      ap_start = 1'b0;
      vld = '0;
      cfg_wr_en = 1'b0;
      cfg_port = '0;
      cfg_dest_leaf = '0;
      cfg_dest_port = '0;
      credit_upd_vld = 1'b0;
      credit_upd_port = '0;
      dout_rdy = 1'b1;
      base[0] = 32'hA5A5_0000;
      base[1] = 32'hB000_0000;
      base[2] = 32'hC000_0000;
      for (int i = 0; i < 3; i++) begin
         cnt[i] = '0;
         leaf_m[i] = '0;
         port_m[i] = '0;
      end
      model_reset();
      drive_din();

      // Reset values
      #12;
      chk("rst_ack", 49'(ack), 49'(0));
      chk("rst_dout_vld", 49'(dout_vld), 49'(0));
      chk("rst_dout", dout, 49'(0));
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Configure ports 0..2
      cfg_write(3'd0, 5'd3, 4'd1); step(3'b000);
      cfg_write(3'd1, 5'd4, 4'd2); step(3'b000);
      cfg_write(3'd2, 5'd5, 4'd3); step(3'b000);
      cfg_wr_en = 1'b0;

      // First word on port 0
      ap_start = 1'b1;
      step(3'b000);
      vld = 3'b001;
      step(3'b001);
      vld = 3'b000;
      chk("first_pkt", dout, {1'b1, 5'd3, 4'd1, 7'd0, 32'hA5A5_0000});
      step(3'b000);

      // All ports valid: rotation continues after port 0
      vld = 3'b111;
      for (int k = 0; k < 7; k++) step(3'b001 << ((k + 1) % 3));

      // Downstream stall with a packet pending, then release
      dout_rdy = 1'b0;
      repeat (4) step(3'b000);
      dout_rdy = 1'b1;
      step(3'b100);
      step(3'b001);

      // Asynchronous reset while a packet is held
      chk("vld_before_reset", 49'(dout_vld), 49'(1));
      reset = 1'b1;
      #1;
      chk("async_rst_vld", 49'(dout_vld), 49'(0));
      chk("async_rst_ack", 49'(ack), 49'(0));
      chk("async_rst_dout", dout, 49'(0));
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      step(3'b000);
      cfg_write(3'd7, 5'd1, 4'd1); step(3'b000);
      cfg_wr_en = 1'b0;
      step(3'b000);

      // Port 0 only: drain all credits, refill, drain again
      cfg_write(3'd0, 5'd3, 4'd1); step(3'b000);
      vld = 3'b001;
      cfg_write(3'd1, 5'd4, 4'd2);
      for (int k = 0; k < 130; k++) begin
         step(has_credit(0) ? 3'b001 : 3'b000);
         cfg_wr_en = 1'b0;
      end
      credit_upd_vld  = 1'b1;
      credit_upd_port = 3'd0;
      step(has_credit(0) ? 3'b001 : 3'b000);
      credit_upd_vld = 1'b0;
      for (int k = 0; k < 70; k++) step(has_credit(0) ? 3'b001 : 3'b000);

      // Port 1: 130 words with continuous updates; sequence address wraps
      vld = 3'b010;
      credit_upd_vld  = 1'b1;
      credit_upd_port = 3'd1;
      for (int k = 0; k < 130; k++) begin
         step(has_credit(1) ? 3'b010 : 3'b000);
         if (k == 128) chk("seq_wrap", 49'(dout[38:32]), 49'(0));
      end
      credit_upd_vld = 1'b0;
      vld = 3'b000;
      step(3'b000);
      step(3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
